// File: rtl/cdc_receiver_if.sv
`timescale 1ns/1ps
// Purpose: bundles the handshake-side and downstream-side signals of cdc_receiver.
// Latency: none; this is wiring only.
// Backpressure: dest_ack is withheld by the receiver while Fifo_Full is high.
// Ports:
//   dest_req, dest_in   : word offered by the handshake destination side
//   dest_ack            : acknowledge back to the handshake
//   Data_out/Data_Valid : head of the receive FIFO
//   Data_Read           : downstream pop request
//   Fifo_Full           : FIFO holds FIFO_DEPTH words
//   Word_Count          : accepted-word counter, only with CDC_RECEIVER_WORD_COUNT_EN
// Modports:
//   slave  : the receiver itself
//   master : the environment (handshake side and downstream consumer)
interface cdc_receiver_if #(
  parameter int DATA_LENGTH = 10
);
  logic                   dest_req;
  logic [DATA_LENGTH-1:0] dest_in;
  logic                   dest_ack;
  logic [DATA_LENGTH-1:0] Data_out;
  logic                   Data_Valid;
  logic                   Data_Read;
  logic                   Fifo_Full;
`ifdef CDC_RECEIVER_WORD_COUNT_EN
  logic [15:0]            Word_Count;

  modport slave (
    input  dest_req, dest_in, Data_Read,
    output dest_ack, Data_out, Data_Valid, Fifo_Full, Word_Count
  );
  modport master (
    output dest_req, dest_in, Data_Read,
    input  dest_ack, Data_out, Data_Valid, Fifo_Full, Word_Count
  );
`else
  modport slave (
    input  dest_req, dest_in, Data_Read,
    output dest_ack, Data_out, Data_Valid, Fifo_Full
  );
  modport master (
    output dest_req, dest_in, Data_Read,
    input  dest_ack, Data_out, Data_Valid, Fifo_Full
  );
`endif
endinterface

// File: rtl/cdc_receiver.sv
`timescale 1ns/1ps
// Purpose: destination endpoint of an external-ack handshake CDC; captures words into a FWFT FIFO.
// Latency: word visible on Data_out one cycle after dest_req is sampled (if FIFO was empty); pop is zero-latency.
// Backpressure: when the FIFO is full dest_ack is withheld, stalling the source domain; nothing is dropped.
// Ports:
//   dest_clk : the only clock
//   reset_b  : asynchronous active-low reset, clears everything including storage
//   bus      : cdc_receiver_if slave modport (handshake in, FIFO head out, Data_Read pop)
// Optional feature: define CDC_RECEIVER_WORD_COUNT_EN to add the 16-bit wrapping Word_Count.
module cdc_receiver #(
  parameter int DATA_LENGTH = 10,
  parameter int FIFO_DEPTH  = 4
) (
  input  logic           dest_clk,
  input  logic           reset_b,
  cdc_receiver_if.slave  bus
);

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam logic [AW:0] FULL_CNT = FIFO_DEPTH[AW:0];

  typedef enum logic {IDLE, ACK} state_t;

  state_t                 state_q, state_d;
  logic                   accept;
  logic                   pop;
  logic                   full;
  logic                   valid;
  logic [AW-1:0]          wr_ptr, rd_ptr;
  logic [AW:0]            count;
  logic [DATA_LENGTH-1:0] mem [FIFO_DEPTH];

  assign full  = (count == FULL_CNT);
  assign valid = (count != '0);
  assign pop   = valid && bus.Data_Read;

  // Ack FSM: state register
  always_ff @(posedge dest_clk or negedge reset_b) begin
    if (!reset_b) state_q <= IDLE;
    else          state_q <= state_d;
  end

  // Ack FSM: next state and write strobe. The full test uses the pre-pop
  // count, so a pop on the same edge only unblocks the write one edge later.
  always_comb begin
    state_d = state_q;
    accept  = 1'b0;
    case (state_q)
      IDLE: begin
        if (bus.dest_req && !full) begin
          accept  = 1'b1;
          state_d = ACK;
        end
      end
      ACK: begin
        // Holding dest_req high here never produces a second write.
        if (!bus.dest_req) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // FIFO pointers, count and storage
  always_ff @(posedge dest_clk or negedge reset_b) begin
    if (!reset_b) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
      for (int i = 0; i < FIFO_DEPTH; i++) mem[i] <= '0;
    end else begin
      if (accept) begin
        mem[wr_ptr] <= bus.dest_in;
        wr_ptr      <= wr_ptr + 1'b1;
      end
      if (pop) rd_ptr <= rd_ptr + 1'b1;
      case ({accept, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  assign bus.dest_ack   = (state_q == ACK);
  assign bus.Data_out   = mem[rd_ptr];
  assign bus.Data_Valid = valid;
  assign bus.Fifo_Full  = full;

`ifdef CDC_RECEIVER_WORD_COUNT_EN
  logic [15:0] word_count;

  always_ff @(posedge dest_clk or negedge reset_b) begin
    if (!reset_b)    word_count <= '0;
    else if (accept) word_count <= word_count + 16'd1;
  end

  assign bus.Word_Count = word_count;
`endif

endmodule

// File: tb/tb_cdc_receiver.sv
`timescale 1ns/1ps
// Testbench for cdc_receiver: directed scenarios plus a randomized run against a
// queue-based model of the receive path (ordered, lossless, capacity FIFO_DEPTH).
module tb_cdc_receiver;

  localparam int DL    = 10;
  localparam int DEPTH = 4;

  logic dest_clk;
  logic reset_b;

  cdc_receiver_if #(.DATA_LENGTH(DL)) bus ();

  cdc_receiver #(.DATA_LENGTH(DL), .FIFO_DEPTH(DEPTH)) dut (
    .dest_clk (dest_clk),
    .reset_b  (reset_b),
    .bus      (bus)
  );

  initial begin
    dest_clk = 1'b0;
    forever #5 dest_clk = ~dest_clk;
  end

  int nchk  = 0;
  int nfail = 0;

  // Reference model: words held by the receiver, expected ack level, accepted count.
  logic [DL-1:0] mq[$];
  logic          m_ack;
  int            m_wc;

  // Drive inputs for one rising edge, advance the model, return at the next falling edge.
  task automatic cycle(input logic req, input logic [DL-1:0] din, input logic rd);
    bit acc, pp;
    bus.dest_req  = req;
    bus.dest_in   = din;
    bus.Data_Read = rd;
    @(posedge dest_clk);
    acc = req && !m_ack && (mq.size() < DEPTH);
    pp  = rd && (mq.size() != 0);
    if (pp)  void'(mq.pop_front());
    if (acc) begin mq.push_back(din); m_wc++; end
    m_ack = acc ? 1'b1 : (req ? m_ack : 1'b0);
    @(negedge dest_clk);
  endtask

  task automatic model_reset();
    mq.delete();
    m_ack = 1'b0;
    m_wc  = 0;
  endtask

  task automatic test_reset();
    reset_b = 1'b0;
    bus.dest_req = 1'b0; bus.dest_in = '0; bus.Data_Read = 1'b0;
    model_reset();
    #12;
    nchk++; if (bus.dest_ack !== 1'b0) begin nfail++; $display("FAIL reset_ack got %b want 0", bus.dest_ack); end
    nchk++; if (bus.Data_Valid !== 1'b0) begin nfail++; $display("FAIL reset_valid got %b want 0", bus.Data_Valid); end
    nchk++; if (bus.Fifo_Full !== 1'b0) begin nfail++; $display("FAIL reset_full got %b want 0", bus.Fifo_Full); end
    nchk++; if (bus.Data_out !== 10'h000) begin nfail++; $display("FAIL reset_data got %h want 000", bus.Data_out); end
    @(negedge dest_clk);
    reset_b = 1'b1;
    cycle(1'b0, '0, 1'b0);
    nchk++; if (bus.Data_Valid !== 1'b0) begin nfail++; $display("FAIL post_reset_valid got %b want 0", bus.Data_Valid); end
  endtask

  task automatic test_single_word();
    cycle(1'b1, 10'h2A5, 1'b0);
    nchk++; if (bus.dest_ack !== 1'b1) begin nfail++; $display("FAIL single_ack got %b want 1", bus.dest_ack); end
    nchk++; if (bus.Data_Valid !== 1'b1) begin nfail++; $display("FAIL single_valid got %b want 1", bus.Data_Valid); end
    nchk++; if (bus.Data_out !== 10'h2A5) begin nfail++; $display("FAIL single_data got %h want 2a5", bus.Data_out); end
    // req held high in ACK: still acked, no second write
    cycle(1'b1, 10'h2A5, 1'b0);
    nchk++; if (bus.dest_ack !== 1'b1) begin nfail++; $display("FAIL single_hold_ack got %b want 1", bus.dest_ack); end
    cycle(1'b0, '0, 1'b0);
    nchk++; if (bus.dest_ack !== 1'b0) begin nfail++; $display("FAIL single_drop_ack got %b want 0", bus.dest_ack); end
    cycle(1'b0, '0, 1'b1);
    nchk++; if (bus.Data_Valid !== 1'b0) begin nfail++; $display("FAIL single_no_dup got valid %b want 0", bus.Data_Valid); end
  endtask

  task automatic test_backpressure();
    for (int i = 1; i <= 4; i++) begin
      cycle(1'b1, DL'(i), 1'b0);
      nchk++; if (bus.dest_ack !== 1'b1) begin nfail++; $display("FAIL bp_ack%0d got %b want 1", i, bus.dest_ack); end
      cycle(1'b0, '0, 1'b0);
    end
    nchk++; if (bus.Fifo_Full !== 1'b1) begin nfail++; $display("FAIL bp_full got %b want 1", bus.Fifo_Full); end
    cycle(1'b1, 10'h005, 1'b0);
    cycle(1'b1, 10'h005, 1'b0);
    nchk++; if (bus.dest_ack !== 1'b0) begin nfail++; $display("FAIL bp_withheld got %b want 0", bus.dest_ack); end
    nchk++; if (bus.Data_out !== 10'h001) begin nfail++; $display("FAIL bp_head got %h want 001", bus.Data_out); end
    // pop while full: write is not accepted on this same edge
    cycle(1'b1, 10'h005, 1'b1);
    nchk++; if (bus.dest_ack !== 1'b0) begin nfail++; $display("FAIL bp_same_edge_ack got %b want 0", bus.dest_ack); end
    nchk++; if (bus.Fifo_Full !== 1'b0) begin nfail++; $display("FAIL bp_full_after_pop got %b want 0", bus.Fifo_Full); end
    cycle(1'b1, 10'h005, 1'b0);
    nchk++; if (bus.dest_ack !== 1'b1) begin nfail++; $display("FAIL bp_fifth_ack got %b want 1", bus.dest_ack); end
    nchk++; if (bus.Fifo_Full !== 1'b1) begin nfail++; $display("FAIL bp_refull got %b want 1", bus.Fifo_Full); end
    cycle(1'b0, '0, 1'b0);
    for (int k = 2; k <= 5; k++) begin
      nchk++; if (bus.Data_out !== DL'(k) || bus.Data_Valid !== 1'b1) begin
        nfail++; $display("FAIL bp_drain%0d got %h/%b want %h/1", k, bus.Data_out, bus.Data_Valid, DL'(k));
      end
      cycle(1'b0, '0, 1'b1);
    end
    nchk++; if (bus.Data_Valid !== 1'b0) begin nfail++; $display("FAIL bp_empty got %b want 0", bus.Data_Valid); end
  endtask

  task automatic test_simultaneous();
    cycle(1'b1, 10'h011, 1'b0); cycle(1'b0, '0, 1'b0);
    cycle(1'b1, 10'h022, 1'b0); cycle(1'b0, '0, 1'b0);
    cycle(1'b1, 10'h3FF, 1'b1);
    nchk++; if (bus.dest_ack !== 1'b1) begin nfail++; $display("FAIL sim_ack got %b want 1", bus.dest_ack); end
    nchk++; if (bus.Data_out !== 10'h022) begin nfail++; $display("FAIL sim_head got %h want 022", bus.Data_out); end
    cycle(1'b0, '0, 1'b1);
    nchk++; if (bus.Data_out !== 10'h3FF || bus.Data_Valid !== 1'b1) begin
      nfail++; $display("FAIL sim_last got %h/%b want 3ff/1", bus.Data_out, bus.Data_Valid);
    end
    cycle(1'b0, '0, 1'b1);
    nchk++; if (bus.Data_Valid !== 1'b0) begin nfail++; $display("FAIL sim_count got valid %b want 0", bus.Data_Valid); end
  endtask

  task automatic test_wraparound();
    for (int i = 0; i < 10; i++) begin
      cycle(1'b1, DL'(10'h100 + i), 1'b1);
      nchk++; if (bus.Data_out !== DL'(10'h100 + i) || bus.Data_Valid !== 1'b1) begin
        nfail++; $display("FAIL wrap%0d got %h/%b want %h/1", i, bus.Data_out, bus.Data_Valid, DL'(10'h100 + i));
      end
      cycle(1'b0, '0, 1'b1);
      nchk++; if (bus.Data_Valid !== 1'b0) begin nfail++; $display("FAIL wrap_dup%0d got valid %b want 0", i, bus.Data_Valid); end
    end
  endtask

  task automatic test_reset_mid();
    cycle(1'b1, 10'h0A1, 1'b0); cycle(1'b0, '0, 1'b0);
    cycle(1'b1, 10'h0A2, 1'b0); cycle(1'b0, '0, 1'b0);
    cycle(1'b1, 10'h0A3, 1'b0);
    #2 reset_b = 1'b0;
    model_reset();
    #1;
    nchk++; if (bus.dest_ack !== 1'b0) begin nfail++; $display("FAIL mid_ack got %b want 0", bus.dest_ack); end
    nchk++; if (bus.Data_Valid !== 1'b0) begin nfail++; $display("FAIL mid_valid got %b want 0", bus.Data_Valid); end
    nchk++; if (bus.Data_out !== 10'h000) begin nfail++; $display("FAIL mid_data got %h want 000", bus.Data_out); end
    @(negedge dest_clk);
    bus.dest_req = 1'b0;
    reset_b = 1'b1;
    cycle(1'b0, '0, 1'b0);
    cycle(1'b0, '0, 1'b1);
    nchk++; if (bus.Data_Valid !== 1'b0) begin nfail++; $display("FAIL mid_stay_empty got %b want 0", bus.Data_Valid); end
    cycle(1'b1, 10'h0AA, 1'b0);
    nchk++; if (bus.Data_out !== 10'h0AA) begin nfail++; $display("FAIL mid_first_word got %h want 0aa", bus.Data_out); end
    cycle(1'b0, '0, 1'b1);
  endtask

  task automatic test_random();
    logic          req = 1'b0;
    logic [DL-1:0] din = '0;
    logic          rd;
    for (int n = 0; n < 800; n++) begin
      nchk++; if (bus.dest_ack !== m_ack) begin nfail++; $display("FAIL rnd_ack@%0d got %b want %b", n, bus.dest_ack, m_ack); end
      nchk++; if (bus.Data_Valid !== (mq.size() != 0)) begin nfail++; $display("FAIL rnd_valid@%0d got %b want %b", n, bus.Data_Valid, mq.size() != 0); end
      nchk++; if (bus.Fifo_Full !== (mq.size() == DEPTH)) begin nfail++; $display("FAIL rnd_full@%0d got %b want %b", n, bus.Fifo_Full, mq.size() == DEPTH); end
      if (mq.size() != 0) begin
        nchk++; if (bus.Data_out !== mq[0]) begin nfail++; $display("FAIL rnd_data@%0d got %h want %h", n, bus.Data_out, mq[0]); end
      end
      // source side of the handshake: offer when ack is low, withdraw once acked
      if (!req && bus.dest_ack === 1'b0 && $urandom_range(0, 2) != 0) begin
        req = 1'b1;
        din = DL'($urandom);
      end else if (req && bus.dest_ack === 1'b1) begin
        req = 1'b0;
      end
      rd = (n < 400) ? ($urandom_range(0, 3) == 0) : ($urandom_range(0, 3) != 0);
      cycle(req, din, rd);
    end
    for (int n = 0; n < 8; n++) cycle(1'b0, '0, 1'b1);
    nchk++; if (bus.Data_Valid !== 1'b0) begin nfail++; $display("FAIL rnd_drained got %b want 0", bus.Data_Valid); end
  endtask

`ifdef CDC_RECEIVER_WORD_COUNT_EN
  task automatic test_word_count();
    @(negedge dest_clk);
    reset_b = 1'b0;
    model_reset();
    #1;
    nchk++; if (bus.Word_Count !== 16'd0) begin nfail++; $display("FAIL wc_reset got %0d want 0", bus.Word_Count); end
    @(negedge dest_clk);
    reset_b = 1'b1;
    for (int i = 0; i < 10; i++) begin
      cycle(1'b1, DL'(i), 1'b1);
      cycle(1'b1, DL'(i), 1'b1);
      cycle(1'b0, '0, 1'b1);
    end
    nchk++; if (bus.Word_Count !== 16'd10) begin nfail++; $display("FAIL wc_ten got %0d want 10", bus.Word_Count); end
    nchk++; if (bus.Word_Count !== 16'(m_wc)) begin nfail++; $display("FAIL wc_model got %0d want %0d", bus.Word_Count, m_wc); end
  endtask
`endif

  initial begin
    test_reset();
    test_single_word();
    test_backpressure();
    test_simultaneous();
    test_wraparound();
    test_reset_mid();
    test_random();
`ifdef CDC_RECEIVER_WORD_COUNT_EN
    test_word_count();
`endif
    $display("End of test - %0d assertions evaluated, %0d failures", nchk, nfail);
    $finish;
  end

endmodule

// File: doc/cdc_receiver.md
# cdc_receiver

Destination-side endpoint of the handshake clock-domain crossing: runs in the destination clock domain and drives the external-acknowledge side of `xpm_cdc_handshake` instantiated with `DEST_EXT_HSK=1`. It captures each word presented with `dest_req`, returns `dest_ack`, and buffers words in a small first-word-fall-through FIFO. Downstream logic drains the FIFO with a valid/read handshake. When the FIFO is full, the block withholds the acknowledge, so backpressure propagates to the source domain and no word is dropped.

## Interface
- `DATA_LENGTH`, default 10: word width in bits; must match the handshake `WIDTH`.
- `FIFO_DEPTH`, default 4: number of buffered words; power of two, at least 2.

- `dest_clk` input 1: destination-domain clock; the only clock in the block.
- `reset_b` input 1: asynchronous, active-low reset.
- `dest_req` input 1: from the handshake `dest_req`; high means `dest_in` is stable and new.
- `dest_in` input `DATA_LENGTH`: from the handshake `dest_out`.
- `dest_ack` output 1: to the handshake `dest_ack`.
- `Data_out` output `DATA_LENGTH`: head of the FIFO.
- `Data_Valid` output 1: FIFO is non-empty; `Data_out` is meaningful.
- `Data_Read` input 1: downstream pop request; acts only when `Data_Valid` is high.
- `Fifo_Full` output 1: FIFO count equals `FIFO_DEPTH`.
- `Word_Count` output 16: words accepted since reset. Present only with the macro defined (see Configuration).

## Operation
- **Ack FSM** has two states, `IDLE` and `ACK`; `dest_ack` = (state == `ACK`).
  - `IDLE` → `ACK` when `dest_req` && !`Fifo_Full`. On the same edge, `dest_in` is written at the write pointer.
  - `IDLE` holds when `dest_req` && `Fifo_Full`: no write, no ack. The source stalls until downstream pops.
  - `ACK` → `IDLE` when `dest_req` == 0. `dest_req` staying high in `ACK` never causes a second write.
- **FIFO**
  - Write and read pointers are `log2(FIFO_DEPTH)` bits and wrap naturally.
  - Count is `log2(FIFO_DEPTH)+1` bits.
  - Pop occurs when `Data_Valid` && `Data_Read`.
  - Write and pop on the same edge leave the count unchanged and advance both pointers.
  - `Fifo_Full` is evaluated on the pre-pop count. A pop on the same edge does not unblock a write; the write is accepted on the next edge.
  - `Data_Read` while empty is ignored: pointers and count are unchanged.
- **Reset values:** `dest_ack`=0, `Data_Valid`=0, `Fifo_Full`=0, `Data_out`=0 (storage cleared), pointers=0, count=0, state=`IDLE`, `Word_Count`=0.
- **Reset mid-transfer:** all state clears immediately and `dest_ack` drops asynchronously. The source domain is reset together with this block. If `dest_req` is still high after reset release, that word is captured as a new word.

## Timing
- **Capture latency:** `dest_req` sampled high in `IDLE` at edge N with FIFO not full means `dest_ack`=1 and `Data_Valid`=1 in the cycle after edge N. `Data_out` shows that word if the FIFO was empty.
- `dest_ack` is registered; it falls on the first edge at which `dest_req` is sampled low.
- **Minimum spacing between accepted words:** 2 `dest_clk` cycles on the receiver side. The end-to-end rate is set by handshake synchronizer latency.
- **Pop:** `Data_Read` high at edge M with `Data_Valid` means the next word (or `Data_Valid`=0) appears after edge M. `Data_out` is combinational from storage and the read pointer, so there is zero additional latency.
- `Fifo_Full` updates on the edge of the write or pop that changes the count.

## Configuration
- **`CDC_RECEIVER_WORD_COUNT_EN` defined:**
  - `Word_Count` port exists.
  - Increments by 1 on every accepted write (`IDLE` → `ACK` transition).
  - Wraps 0xFFFF → 0x0000.
  - Reset to 0.
- **Undefined:** the port and the counter are absent; all other behaviour is identical.

## Test plan
- **Single word:** reset, then `dest_in`=0x2A5 with `dest_req`=1.
  - `dest_ack`=1 and `Data_Valid`=1 with `Data_out`=0x2A5 one cycle after the sampling edge.
  - Drop `dest_req`: `dest_ack`=0 one cycle later.
- **Backpressure:** `FIFO_DEPTH`=4 with `Data_Read`=0; send 0x001–0x005.
  - The first four words are acked; `Fifo_Full`=1.
  - The fifth word sees `dest_ack` held at 0.
  - One pop of 0x001, then the fifth word is acked on the following edge.
  - Drain order is 0x002, 0x003, 0x004, 0x005.
- **Simultaneous write and pop:** with 2 words queued, pop on the same edge as a write of 0x3FF.
  - Count stays 2; `Data_out` advances to the second word.
  - 0x3FF is delivered last.
- **Wrap-around:** stream 10 words 0x100–0x109 with `Data_Read` held at 1.
  - All 10 are received in order with no duplicates.
  - Pointers pass through 3→0 twice.
- **Reset mid-transfer:** assert `reset_b`=0 while in `ACK` with 3 words queued.
  - `dest_ack`=0, `Data_Valid`=0, `Data_out`=0 immediately.
  - After release with `dest_req`=0, the FIFO stays empty.
- **Word count (macro defined):** after 10 accepted words, `Word_Count`=10.
  - Preload via 65535 accepted words; the next accept gives `Word_Count`=0.
